// File: rtl/hdmi_var_delay_line.sv
// Runtime-programmable delay line for the HDMI path: delays a word by 1..G_MAX_DEPTH
// enabled beats through a circular buffer, with beat enable, flush and a primed flag.
module hdmi_var_delay_line #(
  parameter int G_WIDTH     = 40,
  parameter int G_MAX_DEPTH = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_en,
  input  logic                             i_flush,
  input  logic [$clog2(G_MAX_DEPTH):0]     i_delay,
  input  logic [G_WIDTH-1:0]               i_d,
  output logic [G_WIDTH-1:0]               o_q,
  output logic                             o_valid,
  output logic [$clog2(G_MAX_DEPTH):0]     o_delay
);

  localparam int L_PW = $clog2(G_MAX_DEPTH);
  localparam logic [L_PW:0]   L_MAX  = (L_PW+1)'(G_MAX_DEPTH);
  localparam logic [L_PW:0]   L_ONE  = (L_PW+1)'(1);
  localparam logic [L_PW-1:0] L_PINC = L_PW'(1);
  localparam logic [L_PW+1:0] L_FINC = (L_PW+2)'(1);

  logic [G_WIDTH-1:0] mem [G_MAX_DEPTH];
  logic [L_PW-1:0]    wptr;
  logic [L_PW:0]      fill;

  logic [L_PW:0]      d_req;
  logic               dly_chg;
  logic               wr_en;
  logic               primed;
  logic [L_PW-1:0]    rd_addr;
  logic [G_WIDTH-1:0] rd_word;

  always_comb begin
    d_req = i_delay;
    if (i_delay == '0)
      d_req = L_ONE;
    else if (i_delay > L_MAX)
      d_req = L_MAX;
    dly_chg = (d_req != o_delay);
    wr_en   = i_en & ~i_flush;
    // wptr-(D-1) == wptr+1-D; D mod depth is just the low bits (D==MAX wraps to 0).
    rd_addr = wptr + L_PINC - o_delay[L_PW-1:0];
    primed  = ({1'b0, fill} + L_FINC) >= {1'b0, o_delay};
    rd_word = (o_delay == L_ONE) ? i_d : mem[rd_addr];
  end

  // RAM is deliberately not reset; stale entries are masked by fill.
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wptr] <= i_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q     <= '0;
      o_valid <= 1'b0;
      o_delay <= L_ONE;
      wptr    <= '0;
      fill    <= '0;
    end else begin
      if (wr_en)
        wptr <= wptr + L_PINC;
      if (dly_chg) begin
        o_delay <= d_req;
        o_q     <= '0;
        o_valid <= 1'b0;
        fill    <= wr_en ? L_ONE : '0;
      end else if (i_flush) begin
        o_q     <= '0;
        o_valid <= 1'b0;
        fill    <= '0;
      end else if (i_en) begin
        fill <= (fill == L_MAX) ? fill : fill + L_ONE;
        if (primed) begin
          o_q     <= rd_word;
          o_valid <= 1'b1;
        end else begin
          o_q     <= '0;
          o_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_var_delay_line.sv
// Bench for hdmi_var_delay_line: directed scenarios plus random traffic against a
// queue-based reference of the written history.
module tb_hdmi_var_delay_line;

  localparam int W   = 40;
  localparam int MAX = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          flush;
  logic [5:0]    delay;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          valid;
  logic [5:0]    odelay;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] hist[$];
  logic [W-1:0] m_q;
  logic         m_valid;
  int           m_delay;

  always #5 clk = ~clk;

  hdmi_var_delay_line #(.G_WIDTH(W), .G_MAX_DEPTH(MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_flush(flush),
    .i_delay(delay), .i_d(d), .o_q(q), .o_valid(valid), .o_delay(odelay)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_q = '0;
    m_valid = 1'b0;
    m_delay = 1;
  endtask

  // Output is the word written D-1 enabled beats ago, once D words are in history.
  task automatic model_clk();
    int dreq;
    bit wr;
    dreq = (delay == 0) ? 1 : (int'(delay) > MAX) ? MAX : int'(delay);
    wr = en && !flush;
    if (dreq != m_delay) begin
      m_delay = dreq;
      m_q = '0;
      m_valid = 1'b0;
      hist.delete();
      if (wr) hist.push_back(d);
    end else if (flush) begin
      hist.delete();
      m_q = '0;
      m_valid = 1'b0;
    end else if (en) begin
      hist.push_back(d);
      if (hist.size() > MAX) void'(hist.pop_front());
      if (hist.size() >= m_delay) begin
        m_q = hist[hist.size() - m_delay];
        m_valid = 1'b1;
      end else begin
        m_q = '0;
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_clk();
    chk({tag, ".q"}, 64'(q), 64'(m_q));
    chk({tag, ".valid"}, 64'(valid), 64'(m_valid));
    chk({tag, ".delay"}, 64'(odelay), 64'(m_delay));
  endtask

  task automatic seq_index(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      d = W'(i);
      step(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; delay = 6'd1; d = '0;
    model_reset();
    #12;
    chk("rst.q", 64'(q), 64'd0);
    chk("rst.valid", 64'(valid), 64'd0);
    chk("rst.delay", 64'(odelay), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // fixed 11-beat delay on an index ramp
    en = 1'b1; delay = 6'd11;
    seq_index("t1", 30);
    chk("t1.q_at_29", 64'(q), 64'd19);

    // clamping of 0 and oversize requests
    delay = 6'd0;
    for (int i = 0; i < 6; i++) begin d = W'(100 + i); step("t2a"); end
    chk("t2a.d1_passthru", 64'(q), 64'd105);
    delay = 6'd63;
    seq_index("t2b", 40);
    chk("t2b.clamp", 64'(odelay), 64'd32);

    // enable toggling at D=4
    delay = 6'd4;
    for (int i = 0; i < 24; i++) begin
      en = (i % 2 == 0);
      d = W'(200 + i);
      step("t3");
    end
    en = 1'b1;

    // delay change mid-stream
    delay = 6'd8;
    seq_index("t4a", 20);
    delay = 6'd3;
    d = W'(77);
    step("t4b");
    chk("t4b.valid_drop", 64'(valid), 64'd0);
    seq_index("t4c", 10);

    // flush, then flush coinciding with a delay change
    flush = 1'b1; d = W'(999); step("t5a");
    flush = 1'b0;
    seq_index("t5b", 8);
    flush = 1'b1; delay = 6'd5; step("t5c");
    flush = 1'b0;
    seq_index("t5d", 10);

    // asynchronous reset mid-stream
    delay = 6'd11;
    seq_index("t6a", 15);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6.async_q", 64'(q), 64'd0);
    chk("t6.async_valid", 64'(valid), 64'd0);
    chk("t6.async_delay", 64'(odelay), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seq_index("t6b", 30);
    chk("t6b.q_at_29", 64'(q), 64'd19);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) delay = 6'($urandom_range(0, 63));
      d = {8'($urandom), $urandom};
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
